// File: rtl/reg_a_stage.sv
// Register A of the datapath: executes NOP/LOAD/INC/DEC over a valid/ready handshake, one command per two cycles.
// Define REG_A_SAT_EN to make INC/DEC saturate instead of wrapping.
module reg_a_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] a_out,
  output logic             done,
  output logic             zero,
  output logic             carry
);

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_LOAD = 2'b01, OP_INC = 2'b10, OP_DEC = 2'b11} op_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = '1;

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic             hs, commit;
  logic [WIDTH-1:0] res;
  logic             res_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_comb begin
    cmd_ready = (state_q == IDLE) && !clr;
    hs        = cmd_valid && cmd_ready;
    commit    = (state_q == EXEC) && !clr;
  end

  // Result of the latched command against the current register value
  always_comb begin
    res   = a_out;
    res_c = 1'b0;
    case (op_q)
      OP_LOAD: res = data_q;
      OP_INC: begin
        if (a_out == ONES) begin
`ifdef REG_A_SAT_EN
          res = ONES;
`else
          res = '0;
`endif
          res_c = 1'b1;
        end else begin
          res = a_out + ONE;
        end
      end
      OP_DEC: begin
        if (a_out == '0) begin
`ifdef REG_A_SAT_EN
          res = '0;
`else
          res = ONES;
`endif
          res_c = 1'b1;
        end else begin
          res = a_out - ONE;
        end
      end
      default: res = a_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_NOP;
      data_q <= '0;
    end else if (hs) begin
      op_q   <= op_t'(cmd_op);
      data_q <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out <= RESET_VAL;
      zero  <= (RESET_VAL == '0);
      carry <= 1'b0;
      done  <= 1'b0;
    end else if (clr) begin
      a_out <= RESET_VAL;
      zero  <= (RESET_VAL == '0);
      carry <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= commit;
      if (commit) begin
        a_out <= res;
        zero  <= (res == '0);
        carry <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_reg_a_stage.sv
// Bench for reg_a_stage: directed scenarios plus random traffic checked against a
// transaction-level model (integer arithmetic on the register value).
module tb_reg_a_stage;
  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1, clr = 1'b0, cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] data_in = 8'h00;
  logic       cmd_ready, done, zero, carry;
  logic [7:0] a_out;

  reg_a_stage #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .data_in(data_in), .a_out(a_out), .done(done), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, done_cnt = 0;
  // model: register value, flags, and whether a command is waiting to commit
  int m_a = 0, m_op = 0, m_data = 0;
  bit m_c = 0, m_done = 0, m_busy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_c = 0; m_done = 0; m_busy = 0;
  endtask

  task automatic model_exec();
    case (m_op)
      1: begin m_a = m_data; m_c = 0; end
      2: if (m_a == MAXV) begin
`ifdef REG_A_SAT_EN
           m_a = MAXV;
`else
           m_a = 0;
`endif
           m_c = 1;
         end else begin m_a = m_a + 1; m_c = 0; end
      3: if (m_a == 0) begin
`ifdef REG_A_SAT_EN
           m_a = 0;
`else
           m_a = MAXV;
`endif
           m_c = 1;
         end else begin m_a = m_a - 1; m_c = 0; end
      default: m_c = 0;
    endcase
  endtask

  task automatic check_state(input string pfx);
    check({pfx, "_a"},     32'(a_out), 32'(m_a));
    check({pfx, "_zero"},  32'(zero),  32'(m_a == 0));
    check({pfx, "_carry"}, 32'(carry), 32'(m_c));
    check({pfx, "_done"},  32'(done),  32'(m_done));
  endtask

  // One clock: check at negedge, drive new inputs, then advance the model at posedge
  task automatic step(input bit v, input int op, input int d, input bit c, input bit r);
    @(negedge clk);
    check_state("st");
    if (done === 1'b1) done_cnt++;
    reset = r; clr = c; cmd_valid = v; cmd_op = 2'(op); data_in = 8'(d);
    #1;
    if (r) begin
      model_reset();
      check_state("rst_async");
    end
    check("ready", 32'(cmd_ready), 32'(!m_busy && !c));
    @(posedge clk);
    if (r) model_reset();
    else if (c) model_reset();
    else if (m_busy) begin model_exec(); m_done = 1; m_busy = 0; end
    else begin
      m_done = 0;
      if (v) begin m_busy = 1; m_op = op; m_data = d; end
    end
    #1;
  endtask

  initial begin
    model_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // LOAD 0x5A, data_in changes right after acceptance
    step(1, 1, 8'h5A, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    check("load_a", 32'(a_out), 32'h5A);
    check("load_done", 32'(done), 32'd1);
    step(0, 0, 0, 0, 0);
    check("load_done_pulse", 32'(done), 32'd0);

    // LOAD 0xFF, INC
    step(1, 1, 8'hFF, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0);     step(0, 0, 0, 0, 0);
`ifdef REG_A_SAT_EN
    check("inc_top_a", 32'(a_out), 32'hFF);
`else
    check("inc_top_a", 32'(a_out), 32'h00);
    check("inc_top_zero", 32'(zero), 32'd1);
`endif
    check("inc_top_carry", 32'(carry), 32'd1);

    // LOAD 0x00, DEC
    step(1, 1, 8'h00, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0);     step(0, 0, 0, 0, 0);
`ifdef REG_A_SAT_EN
    check("dec_bot_a", 32'(a_out), 32'h00);
    check("dec_bot_zero", 32'(zero), 32'd1);
`else
    check("dec_bot_a", 32'(a_out), 32'hFF);
`endif
    check("dec_bot_carry", 32'(carry), 32'd1);

    // INC held valid for 6 cycles from 0x10
    step(1, 1, 8'h10, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) step(1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("hold_a", 32'(a_out), 32'h13);
    check("hold_dones", 32'(done_cnt), 32'd3);

    // clr aborts an in-flight LOAD; clr with valid in IDLE is not a handshake
    step(1, 1, 8'h33, 0, 0);
    step(0, 0, 0, 1, 0);
    check("clr_abort_a", 32'(a_out), 32'h00);
    check("clr_abort_done", 32'(done), 32'd0);
    step(1, 1, 8'h44, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("clr_nohs_a", 32'(a_out), 32'h00);
    check("clr_nohs_done", 32'(done), 32'd0);

    // reset in the middle of EXEC
    step(1, 1, 8'hAA, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("rst_mid_a", 32'(a_out), 32'h00);

    for (int i = 0; i < 400; i++) begin
      int p;
      p = int'($urandom_range(0, 99));
      step($urandom_range(0, 99) < 65, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           p < 4, p >= 97);
    end
    step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
